// File: rtl/mtm_alu_serializer_pkg.sv
// Shared types and constants for the ALU output serializer.
// Holds the frame FSM state enum, frame type bits, CTL byte codes and a
// helper that picks the payload byte for a given byte index.
package mtm_alu_serializer_pkg;

  localparam int N_DATA_BYTES = 4;
  localparam int C_W          = 8 * N_DATA_BYTES;
  localparam int FRAME_BITS   = 11;

  localparam logic FRAME_DATA = 1'b0;
  localparam logic FRAME_CTL  = 1'b1;

  localparam logic [7:0] CTL_IDLE   = 8'hFF;
  localparam logic [7:0] CTL_ERR_A5 = 8'hA5;
  localparam logic [7:0] CTL_ERR_C9 = 8'hC9;
  localparam logic [7:0] CTL_ERR_93 = 8'h93;

  // Byte index at which the CTL frame is sent (after all DATA frames).
  localparam logic [2:0] CTL_IDX = 3'(N_DATA_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TYPE,
    ST_PAYLOAD,
    ST_STOP
  } tx_state_e;

  // Index 0 is the most significant C byte; CTL_IDX and above return CTL.
  function automatic logic [7:0] sel_byte(input logic [C_W-1:0] c,
                                          input logic [7:0]     ctl,
                                          input logic [2:0]     idx);
    logic [C_W-1:0] sh;
    sh = c << {idx, 3'b000};
    return (idx >= CTL_IDX) ? ctl : sh[C_W-1 -: 8];
  endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Result handshake between the ALU core (master) and the serializer (slave).
//   C       : 32-bit ALU result
//   CTL_out : status / CRC / error byte
//   valid   : C/CTL_out carry a new result
//   ready   : serializer idle, accepts on valid
interface mtm_alu_serializer_if;
  logic [31:0] C;
  logic [7:0]  CTL_out;
  logic        valid;
  logic        ready;

  modport master (output C, output CTL_out, output valid, input  ready);
  modport slave  (input  C, input  CTL_out, input  valid, output ready);
endinterface

// File: rtl/mtm_alu_serializer_frame_tx.sv
// Single-frame transmitter: on load, latches {type, byte} and shifts out
// start(0), type, 8 payload bits MSB first, stop(1), one bit per clk.
// A load presented during the stop bit chains the next frame with no gap.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load        : start a frame (accepted in IDLE or STOP)
//   frame_type  : 0 = DATA, 1 = CTL
//   frame_byte  : payload byte
//   sout        : registered serial output, idle high
//   done        : high while the stop bit is on the line
module mtm_alu_serializer_frame_tx
  import mtm_alu_serializer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       frame_type,
  input  logic [7:0] frame_byte,
  output logic       sout,
  output logic       done
);

  tx_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       type_q, type_d;
  logic [7:0] byte_q, byte_d;
  logic       sout_q, sout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      type_q  <= FRAME_DATA;
      byte_q  <= '0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      byte_q  <= byte_d;
      sout_q  <= sout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    byte_d  = byte_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (load) begin
        state_d = ST_START;
        type_d  = frame_type;
        byte_d  = frame_byte;
      end
      ST_START: state_d = ST_TYPE;
      ST_TYPE: begin
        state_d = ST_PAYLOAD;
        cnt_d   = 3'd7;
      end
      ST_PAYLOAD: begin
        if (cnt_q == 3'd0) state_d = ST_STOP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_STOP: begin
        done = 1'b1;
        if (load) begin
          state_d = ST_START;
          type_d  = frame_type;
          byte_d  = frame_byte;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // sout is registered: drive the bit belonging to the state being entered.
    sout_d = 1'b1;
    unique case (state_d)
      ST_START:   sout_d = 1'b0;
      ST_TYPE:    sout_d = type_d;
      ST_PAYLOAD: sout_d = byte_d[cnt_d];
      default:    sout_d = 1'b1;
    endcase
  end

  assign sout = sout_q;

endmodule

// File: rtl/mtm_alu_serializer.sv
// ALU output serializer top. Latches one {C, CTL_out} result per handshake
// and sends it as a packet of 11-bit frames:
//   CTL == FF  : no-op, nothing sent
//   CTL[7] = 1 : error packet, CTL frame only
//   CTL[7] = 0 : 4 DATA frames (C MSB byte first) then the CTL frame
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : result handshake (slave side); ready is registered
//   sout       : registered serial line, idle high
module mtm_alu_serializer
  import mtm_alu_serializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  mtm_alu_serializer_if.slave   bus,
  output logic                  sout
);

  logic [C_W-1:0] c_q, c_d;
  logic [7:0]     ctl_q, ctl_d;
  logic [2:0]     byte_cnt_q, byte_cnt_d;
  logic           ready_q, ready_d;

  logic           accept;
  logic           tx_load, tx_type, tx_done;
  logic [7:0]     tx_byte;
  logic [2:0]     idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q        <= '0;
      ctl_q      <= '0;
      byte_cnt_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      c_q        <= c_d;
      ctl_q      <= ctl_d;
      byte_cnt_q <= byte_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign accept = bus.valid && ready_q;

  always_comb begin
    c_d        = c_q;
    ctl_d      = ctl_q;
    byte_cnt_d = byte_cnt_q;
    ready_d    = ready_q;
    tx_load    = 1'b0;
    tx_type    = FRAME_DATA;
    tx_byte    = 8'h00;
    idx        = '0;

    if (accept) begin
      c_d   = bus.C;
      ctl_d = bus.CTL_out;
      if (bus.CTL_out != CTL_IDLE) begin
        // First frame is loaded straight from the bus so the start bit
        // appears on the same edge that accepts the result.
        idx        = bus.CTL_out[7] ? CTL_IDX : 3'd0;
        ready_d    = 1'b0;
        byte_cnt_d = idx;
        tx_load    = 1'b1;
        tx_type    = (idx == CTL_IDX) ? FRAME_CTL : FRAME_DATA;
        tx_byte    = sel_byte(bus.C, bus.CTL_out, idx);
      end
    end else if (tx_done) begin
      if (byte_cnt_q == CTL_IDX) begin
        ready_d    = 1'b1;
        byte_cnt_d = '0;
      end else begin
        // Chain the next frame during the stop bit: no gap between frames.
        idx        = byte_cnt_q + 3'd1;
        byte_cnt_d = idx;
        tx_load    = 1'b1;
        tx_type    = (idx == CTL_IDX) ? FRAME_CTL : FRAME_DATA;
        tx_byte    = sel_byte(c_q, ctl_q, idx);
      end
    end
  end

  mtm_alu_serializer_frame_tx u_frame_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tx_load),
    .frame_type (tx_type),
    .frame_byte (tx_byte),
    .sout       (sout),
    .done       (tx_done)
  );

  assign bus.ready = ready_q;

endmodule
